// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and default widths.
// The COPY operation is only available when LSU_COPY_EN is defined.
package lsu_pkg;

    localparam int LSU_AW = 8;
    localparam int LSU_DW = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_ST,
        S_CP_RD,
        S_CP_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective-address adder plus the source/destination address registers of the LSU.
// The destination register and post-increment exist only when LSU_COPY_EN is defined.
module lsu_addr_gen
    import lsu_pkg::*;
#(
    parameter int AW = LSU_AW,
    parameter int DW = LSU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] base,
    input  logic [DW-1:0] off,
    output logic [AW-1:0] src_addr
`ifdef LSU_COPY_EN
    ,
    input  logic          step,
    input  logic [AW-1:0] dst_start,
    output logic [AW-1:0] dst_addr
`endif
);

    logic [AW-1:0] off_ext;
    logic [AW-1:0] ea;

    // Offset is two's complement; the sum wraps naturally at 2**AW.
    assign off_ext = AW'($signed(off));
    assign ea      = base + off_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr <= '0;
        end else if (load) begin
            src_addr <= ea;
`ifdef LSU_COPY_EN
        end else if (step) begin
            src_addr <= src_addr + AW'(1);
`endif
        end
    end

`ifdef LSU_COPY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_addr <= '0;
        end else if (load) begin
            dst_addr <= dst_start;
        end else if (step) begin
            dst_addr <= dst_addr + AW'(1);
        end
    end
`endif

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory port: LOAD/STORE (and COPY when LSU_COPY_EN is
// defined) requests from the core are sequenced by a small FSM onto mem_ea/mem_wdata/mem_we.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = LSU_AW,
    parameter int DW = LSU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_base,
    input  logic [DW-1:0] req_off,
    input  logic [DW-1:0] req_wdata,
    input  logic [AW-1:0] req_dst,
    input  logic [AW-1:0] req_len,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic [AW-1:0] mem_ea,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_t    state;
    lsu_state_t    state_next;
    logic          accept;
    logic          req_illegal;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] wdata_q;

`ifdef LSU_COPY_EN
    logic          step;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] len_q;
    logic [AW-1:0] count;
    logic [AW-1:0] count_inc;
    logic [DW-1:0] hold;

    assign count_inc = count + AW'(1);
`else
    logic unused_copy_fields;
    assign unused_copy_fields = ^{req_dst, req_len};
`endif

    assign req_ready = (state == S_IDLE);
    assign accept    = req_ready && req_valid;

`ifdef LSU_COPY_EN
    assign req_illegal = (req_op == OP_ILL);
`else
    assign req_illegal = (req_op == OP_ILL) || (req_op == OP_COPY);
`endif

    lsu_addr_gen #(
        .AW(AW),
        .DW(DW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .base     (req_base),
        .off      (req_off),
        .src_addr (src_addr)
`ifdef LSU_COPY_EN
        ,
        .step     (step),
        .dst_start(req_dst),
        .dst_addr (dst_addr)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_LOAD:  state_next = S_LD;
                        OP_STORE: state_next = S_ST;
`ifdef LSU_COPY_EN
                        OP_COPY:  state_next = (req_len == '0) ? S_RESP : S_CP_RD;
`endif
                        default:  state_next = S_RESP;
                    endcase
                end
            end
            S_LD:    state_next = S_RESP;
            S_ST:    state_next = S_RESP;
`ifdef LSU_COPY_EN
            S_CP_RD: state_next = S_CP_WR;
            S_CP_WR: state_next = (count_inc < len_q) ? S_CP_RD : S_RESP;
`endif
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Memory port is parked at zero whenever no access is in flight.
    always_comb begin
        mem_ea    = '0;
        mem_wdata = '0;
`ifdef LSU_COPY_EN
        step      = 1'b0;
`endif
        case (state)
            S_LD: mem_ea = src_addr;
            S_ST: begin
                mem_ea    = src_addr;
                mem_wdata = wdata_q;
            end
`ifdef LSU_COPY_EN
            S_CP_RD: mem_ea = src_addr;
            S_CP_WR: begin
                mem_ea    = dst_addr;
                mem_wdata = hold;
                step      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Reset must kill a write in the same cycle, so the enable is gated combinationally.
    assign mem_we     = !rst && ((state == S_ST) || (state == S_CP_WR));
    assign resp_valid = !rst && (state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
`ifdef LSU_COPY_EN
            len_q     <= '0;
            count     <= '0;
            hold      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wdata_q   <= req_wdata;
                        resp_data <= '0;
                        resp_err  <= req_illegal;
`ifdef LSU_COPY_EN
                        len_q     <= req_len;
                        count     <= '0;
`endif
                    end
                end
                S_LD: resp_data <= mem_rdata;
`ifdef LSU_COPY_EN
                S_CP_RD: hold <= mem_rdata;
                S_CP_WR: begin
                    count     <= count_inc;
                    resp_data <= DW'(count_inc);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
